// File: rtl/charge_requester_pkg.sv
// Shared types for the charge requester: address/charge words, the 2-lane x 4-slot
// request/response shape, the buffered response record and the sweep FSM states.
package defs;

  localparam int NUM_LANES = 2;
  localparam int SLOTS     = 4;
  localparam int ADDR_W    = 16;
  localparam int CHARGE_W  = 16;

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [CHARGE_W-1:0] charge_t;

  typedef addr_t   [NUM_LANES-1:0][SLOTS-1:0] addr_vec_t;
  typedef charge_t [NUM_LANES-1:0][SLOTS-1:0] charge_vec_t;

  typedef struct packed {
    addr_t       base;
    charge_vec_t data;
  } resp_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  // Request n covers cells 8n .. 8n+7, lane-major then slot.
  function automatic addr_vec_t req_addrs(input int unsigned n);
    addr_vec_t v;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int k = 0; k < SLOTS; k++) begin
        v[l][k] = addr_t'(n * (NUM_LANES * SLOTS) + l * SLOTS + k);
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/charge_requester_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; depth must be a
// power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [$clog2(DEPTH):0] ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign do_pop   = pop && !empty;
  assign full     = (count == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/charge_requester.sv
// Sweeps the charge grid eight cells per request, captures the fixed-latency
// scatterer responses and hands them downstream through a credit-guarded FIFO.
module charge_requester
  import defs::*;
#(
  parameter int NCELLS     = 1024,
  parameter int RD_LATENCY = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        valid_req,
  output addr_vec_t   grid_addr_out,
  input  charge_vec_t charge_in,
  output logic        out_valid,
  input  logic        out_ready,
  output charge_vec_t out_data,
  output addr_t       out_base,
  output logic        busy,
  output logic        done
);

  localparam int NREQ = NCELLS / 8;
  localparam int CW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW   = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;

  state_t                 state, state_n;
  logic [CW-1:0]          req_n, req_next;
  logic                   issue, last_sent, room, pop, push;
  logic [OW-1:0]          occ;
  logic [RD_LATENCY-1:0]  vld_sr;
  addr_t [RD_LATENCY-1:0] base_sr;
  resp_t                  push_word, pop_word;
  logic                   fifo_full, fifo_empty;
  logic [CNTW-1:0]        fifo_count;

  assign pop       = out_valid && out_ready;
  assign push      = vld_sr[RD_LATENCY-1];
  assign push_word = '{base: base_sr[RD_LATENCY-1], data: charge_in};
  assign last_sent = valid_req && (req_n == CW'(NREQ - 1));
  assign req_next  = (state == IDLE) ? '0 : req_n + CW'(1);

  // Every driven or in-flight request owns a FIFO slot; issue only if one is left
  // once this cycle's pop has freed its entry.
  assign occ  = OW'(fifo_count) + OW'($countones(vld_sr)) + OW'(valid_req);
  assign room = (occ - OW'(pop)) < OW'(FIFO_DEPTH);

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          issue   = 1'b1;
        end
      end
      ISSUE: begin
        if (last_sent) state_n = DRAIN;
        else           issue   = room;
      end
      DRAIN: begin
        if ((vld_sr == '0) && ((fifo_count - CNTW'(pop)) == '0)) state_n = FIN;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_req     <= 1'b0;
      req_n         <= '0;
      grid_addr_out <= '0;
      vld_sr        <= '0;
      base_sr       <= '0;
    end else begin
      valid_req <= issue;
      if (issue) begin
        req_n         <= req_next;
        grid_addr_out <= req_addrs(32'(req_next));
      end
      vld_sr[0]  <= valid_req;
      base_sr[0] <= grid_addr_out[0][0];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        base_sr[i] <= base_sr[i-1];
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(resp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (pop_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? pop_word.data : '0;
  assign out_base  = out_valid ? pop_word.base : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  push_not_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_charge_requester.sv
// Randomised bench: a latency-accurate scatterer model feeds the DUT and a monitor
// checks requests and output words against the cell-order reference sequence.
module tb_charge_requester;
  import defs::*;

  localparam int NCELLS     = 128;
  localparam int RD_LATENCY = 3;
  localparam int FIFO_DEPTH = 8;
  localparam int NREQ       = NCELLS / 8;

  logic        clk = 1'b0;
  logic        rst, start, valid_req, out_valid, out_ready, busy, done;
  addr_vec_t   grid_addr_out;
  charge_vec_t charge_in, out_data;
  addr_t       out_base;

  int total = 0;
  int bad   = 0;
  int cyc = 0, start_cyc = 0, ready_mode = 0;
  int req_idx, out_idx, done_cnt, first_req, last_req, first_out, last_out, done_rel, idle_rel;
  bit          quiet = 1'b0;
  bit          prev_stall = 1'b0;
  addr_t       prev_base;
  charge_vec_t prev_data;
  addr_vec_t   last_addr = '0;
  charge_t     salt = '0;
  addr_vec_t   sched [int];

  always #5 clk = ~clk;

  charge_requester #(
    .NCELLS     (NCELLS),
    .RD_LATENCY (RD_LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .valid_req     (valid_req),
    .grid_addr_out (grid_addr_out),
    .charge_in     (charge_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_base      (out_base),
    .busy          (busy),
    .done          (done)
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic charge_t chargeOf(input addr_t a);
    return charge_t'(a ^ salt);
  endfunction

  function automatic addr_vec_t expAddrs(input int idx);
    addr_vec_t v;
    for (int l = 0; l < 2; l++)
      for (int k = 0; k < 4; k++)
        v[l][k] = addr_t'(8 * idx + 4 * l + k);
    return v;
  endfunction

  function automatic charge_vec_t expData(input int idx);
    charge_vec_t v;
    for (int l = 0; l < 2; l++)
      for (int k = 0; k < 4; k++)
        v[l][k] = chargeOf(addr_t'(8 * idx + 4 * l + k));
    return v;
  endfunction

  task automatic resetModel();
    req_idx = 0; out_idx = 0; done_cnt = 0;
    first_req = -1; last_req = -1; first_out = -1; last_out = -1;
    done_rel = -1; idle_rel = -1;
    prev_stall = 1'b0;
    salt = charge_t'($urandom);
  endtask

  // Scatterer model and out_ready driver: inputs change 1 time unit after each edge.
  initial begin
    out_ready = 1'b0;
    charge_in = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (ready_mode)
        1:       out_ready = 1'b1;
        2:       out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b0;
      endcase
      if (sched.exists(cyc)) begin
        for (int l = 0; l < 2; l++)
          for (int k = 0; k < 4; k++)
            charge_in[l][k] = chargeOf(sched[cyc][l][k]);
        sched.delete(cyc);
      end else begin
        charge_in = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    int rel;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        rel = cyc - start_cyc;
        if (valid_req) begin
          checkOutput("req_addr", grid_addr_out, expAddrs(req_idx));
          if (first_req < 0) first_req = rel;
          last_req = rel;
          req_idx++;
          last_addr = grid_addr_out;
          sched[cyc + RD_LATENCY] = grid_addr_out;
        end else begin
          checkOutput("addr_hold", grid_addr_out, last_addr);
        end
        if (prev_stall) begin
          checkOutput("stall_base", out_base, prev_base);
          checkOutput("stall_data", out_data, prev_data);
        end
        if (quiet) checkOutput("quiet_valid", out_valid, 0);
        if (out_valid && out_ready) begin
          checkOutput("out_base", out_base, 8 * out_idx);
          checkOutput("out_data", out_data, expData(out_idx));
          if (first_out < 0) first_out = rel;
          last_out = rel;
          out_idx++;
        end
        prev_stall = out_valid && !out_ready;
        prev_base  = out_base;
        prev_data  = out_data;
        checkOutput("credit", (req_idx - out_idx) <= FIFO_DEPTH, 1);
        if (done) begin
          done_cnt++;
          done_rel = rel;
        end
        if (!busy && idle_rel < 0 && rel > 0) idle_rel = rel;
      end
    end
  end

  task automatic applyStimulus(input int mode, input bit extra_starts, input int hold, input bit timing);
    int rel;
    bit finished;
    @(posedge clk);
    #1;
    resetModel();
    ready_mode = (hold > 0) ? 0 : mode;
    start      = 1'b1;
    start_cyc  = cyc;
    finished   = 1'b0;
    for (int i = 0; i < NREQ * 40 + 200 && !finished; i++) begin
      @(posedge clk);
      #1;
      rel   = cyc - start_cyc;
      start = extra_starts && (rel == 3 || rel == 10);
      if (hold > 0 && rel == hold) begin
        checkOutput("bp_requests", req_idx, FIFO_DEPTH);
        checkOutput("bp_full", {out_valid, valid_req}, 2'b10);
        ready_mode = mode;
      end
      if (done_cnt > 0 && !busy) finished = 1'b1;
    end
    start = 1'b0;
    @(negedge clk);
    #1;
    if (!finished) checkOutput("timeout", 0, 1);
    checkOutput("req_count", req_idx, NREQ);
    checkOutput("word_count", out_idx, NREQ);
    checkOutput("done_pulses", done_cnt, 1);
    if (timing) begin
      checkOutput("t_first_req", first_req, 1);
      checkOutput("t_last_req", last_req, NREQ);
      checkOutput("t_first_out", first_out, RD_LATENCY + 2);
      checkOutput("t_last_out", last_out, NREQ + RD_LATENCY + 1);
      checkOutput("t_done", done_rel, NREQ + RD_LATENCY + 2);
      checkOutput("t_idle", idle_rel, NREQ + RD_LATENCY + 3);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ctrl", {valid_req, out_valid, busy, done}, 4'b0000);
    checkOutput("rst_addr", grid_addr_out, 0);
    checkOutput("rst_data", out_data, 0);
    checkOutput("rst_base", out_base, 0);
    rst = 1'b0;

    applyStimulus(1, 1'b0, 0, 1'b1);
    applyStimulus(1, 1'b1, 0, 1'b1);
    applyStimulus(1, 1'b0, 30, 1'b0);
    for (int s = 0; s < 3; s++) applyStimulus(2, 1'b0, 0, 1'b0);

    @(posedge clk);
    #1;
    resetModel();
    ready_mode = 1;
    start      = 1'b1;
    start_cyc  = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc - start_cyc < 4) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst       = 1'b1;
    last_addr = '0;
    #1;
    checkOutput("mid_rst_ctrl", {valid_req, out_valid, busy, done}, 4'b0000);
    checkOutput("mid_rst_addr", grid_addr_out, 0);
    checkOutput("mid_rst_data", out_data, 0);
    checkOutput("mid_rst_base", out_base, 0);
    quiet = 1'b1;
    resetModel();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("post_rst_busy", busy, 0);
    quiet = 1'b0;
    applyStimulus(2, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/charge_requester.md
CHARGE_REQUESTER -- requirements
Module: charge_requester

Interface
REQ-001 Parameter NCELLS, default 1024: grid cells per sweep; multiple of 8.
REQ-002 Parameter RD_LATENCY, default 3: fixed cycles from a valid_req cycle to the matching charge_in cycle.
REQ-003 Parameter FIFO_DEPTH, default 8: response buffer entries; power of 2, at least RD_LATENCY+1.
REQ-004 Port clk, input, 1: single clock. Reset is asynchronous and active-high.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: one-cycle pulse that begins a full grid sweep.
REQ-007 Port valid_req, output, 1: request strobe to the scatterer.
REQ-008 Port grid_addr_out, output, addr_t [3:0] x 2 lanes: request addresses.
REQ-009 Port charge_in, input, charge_t [3:0] x 2 lanes: scatterer response.
REQ-010 Port out_valid, output, 1: out_data/out_base valid.
REQ-011 Port out_ready, input, 1: downstream accepts the word when high with out_valid.
REQ-012 Port out_data, output, charge_t [3:0] x 2 lanes: 8 charges.
REQ-013 Port out_base, output, addr_t: address of out_data lane 0 slot 0.
REQ-014 Port busy, output, 1: high in every state except IDLE.
REQ-015 Port done, output, 1: one-cycle pulse when a sweep completes.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, DRAIN, FIN.
- IDLE -> ISSUE on start.
- ISSUE -> DRAIN after the last request.
- DRAIN -> FIN when no responses are in flight and the FIFO is empty.
- FIN -> IDLE after one cycle, with done=1 during FIN.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 Request n (n = 0..NCELLS/8-1) SHALL drive lane l, slot k with address 8n+4l+k.
REQ-019 Requests SHALL be issued in order n = 0, 1, ...
REQ-020 The first request SHALL be driven no earlier than the cycle after start is sampled.
REQ-021 valid_req SHALL assert only in ISSUE, and only when credit > 0.
- credit = FIFO_DEPTH - fifo_count - inflight.
- inflight = number of requests issued but not yet captured (at most RD_LATENCY).
REQ-022 With out_ready held high, ISSUE SHALL issue one request per cycle with no bubbles.
REQ-023 grid_addr_out SHALL hold its last value while valid_req=0.
REQ-024 For a request driven at cycle t, charge_in SHALL be captured at cycle t+RD_LATENCY, tagged with base 8n.
- Capture uses a RD_LATENCY-deep valid/base shift register.
- The capture is pushed into the FIFO.
REQ-025 The FIFO SHALL be first-word-fall-through.
REQ-026 out_valid SHALL rise the cycle after a push into an empty FIFO, giving latency RD_LATENCY+1 from valid_req.
REQ-027 A pop SHALL occur only when out_valid && out_ready.
REQ-028 out_data and out_base SHALL stay stable while out_valid && !out_ready.
REQ-029 A simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-030 FIFO overflow SHALL be impossible by construction (credit rule).
REQ-031 A push when full is a design error, flagged by an assertion.
REQ-032 The request counter SHALL not wrap: ISSUE ends at n = NCELLS/8-1.
REQ-033 There SHALL be no addresses >= NCELLS.
REQ-034 Charges SHALL pass through unmodified; no arithmetic is applied.
REQ-035 Counter widths SHALL be clog2(NCELLS/8) for the request counter and clog2(FIFO_DEPTH)+1 for fifo_count.

Reset
REQ-036 On rst, all of the following SHALL clear asynchronously:
- outputs: valid_req, out_valid, busy, done = 0; grid_addr_out, out_data, out_base = 0;
- state = IDLE;
- counters, FIFO pointers and shift register = 0.
REQ-037 Reset asserted mid-sweep SHALL discard all in-flight and buffered responses.
REQ-038 Responses arriving after reset deassertion SHALL be ignored.
REQ-039 The first start after reset SHALL begin a fresh sweep at address 0.

Structure
REQ-040 addr_t, charge_t, and the 2-lane x 4-slot array shape SHALL come from package defs.
REQ-041 The package SHALL also define the constants NUM_LANES=2 and SLOTS=4.
REQ-042 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised on width and depth, with full, empty and count outputs.

Verification
REQ-043 Basic sweep. NCELLS=64, RD_LATENCY=3, out_ready=1, scatterer model returns charge=address; pulse start at cycle 0.
- valid_req high cycles 1-8 with bases 0, 8, ..., 56.
- out_valid cycles 5-12, each word data[l][k] = base+4l+k.
- done=1 at cycle 13, busy low at cycle 14.
REQ-044 Backpressure. out_ready=0 from start.
- valid_req stops after exactly 8 requests; the FIFO holds 8 words.
- Raise out_ready: one word pops per cycle and requests resume with no loss or duplication (64 unique addresses total).
REQ-045 Random out_ready (50%) over NCELLS=1024.
- Out words arrive in order, bases 0..1016.
- No push when full; exactly one done pulse.
REQ-046 start pulsed at cycles 3 and 10 during a sweep: no effect, with identical output to REQ-043.
REQ-047 rst asserted at cycle 4 of a sweep.
- All outputs are 0 immediately; no out_valid follows.
- A new start yields a complete sweep from address 0.
